uart_cmd_parser: RTL and testbench
==================================

# uart_cmd_parser

Consumes the received-byte stream from the UART receiver and turns ASCII command lines into single-cycle action pulses for the pet-state logic (feed, play, clean, sleep, wake, medicine, status dump). It sits directly downstream of the UART receiver's `dataIn_R` output and upstream of the stat counters and the status-print trigger. Grammar per line: one command letter, optional decimal amount, then CR or LF.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 27_000_000 — idle cycles allowed between bytes inside a command (1 s at 27 MHz).
- `DEFAULT_ARG`, default 1 — amount used when no digits are given.

Ports:
- `clk` in 1 — system clock, 27 MHz; single clock domain.
- `rst` in 1 — reset; synchronous, active-high.
- `rx_byte` in 8 — UART received byte; 8'h00 when no byte is ready, held nonzero while ready.
- `cmd_valid` out 1 — one-cycle pulse: a complete, legal command was parsed.
- `cmd_code` out 3 — command code; valid with `cmd_valid`, held until the next one.
- `cmd_arg` out 4 — amount 0..15; valid with `cmd_valid`, held.
- `err` out 1 — one-cycle pulse on any parse error or timeout.
- `err_count` out 8 — saturating count of `err` pulses.
- `busy` out 1 — high while a command is partially received (state ARG).

## Operation
- New-byte detect: byte event in cycle N when `rx_byte != 0` and the registered previous `rx_byte == 0`; the held value is ignored. Byte 8'h00 is never a byte event.
- Letters are case-insensitive. Codes: F=1 FEED, P=2 PLAY, C=3 CLEAN, S=4 SLEEP, W=5 WAKE, M=6 MEDS, `?`=7 STATUS. 0 is reserved.
- State IDLE:
  - command char: latch code, accumulator := 0, digit flag := 0, overflow := 0, go to ARG.
  - CR (0x0D), LF (0x0A), or space: ignored.
  - any other byte: `err`, stay in IDLE.
- State ARG:
  - digit '0'..'9': acc := acc*10 + d (8-bit acc), set digit flag. If the result exceeds 15, set overflow and freeze acc.
  - CR or LF:
    - no overflow: `cmd_valid` pulses, `cmd_arg` = acc if digit flag is set, else `DEFAULT_ARG`; go to IDLE.
    - overflow set: `err`, go to IDLE.
  - space: ignored.
  - any other byte, including a second letter: `err`, discard the command, go to IDLE. The byte is not reinterpreted as a new command.
  - timeout: the counter resets on entry to ARG and on every byte event. When it reaches `TIMEOUT_CYCLES`-1: `err`, go to IDLE.
- `err_count` increments on every `err` pulse and saturates at 255.
- `busy` = (state == ARG).

## Timing
- Byte event in cycle N → `cmd_valid`/`err` asserted in cycle N+1 for exactly one cycle. `cmd_code`/`cmd_arg` update in the same cycle N+1.
- Timeout expiry and a byte event in the same cycle: the byte wins; it is processed and the counter resets.
- `cmd_valid` and `err` are never asserted in the same cycle.
- Back-to-back commands need no gap beyond UART byte spacing. The parser accepts one byte event every 2 cycles minimum.
- Reset (any state, including mid-command):
  - state IDLE, acc 0, timeout counter 0.
  - `cmd_valid` 0, `err` 0, `cmd_code` 0, `cmd_arg` 0, `err_count` 0, `busy` 0.
  - previous-byte register := 8'h00, so a byte already held on `rx_byte` when reset releases produces one event.

## Structure
- Shared package `tama_pkg`:
  - command-code localparams `CMD_NONE`..`CMD_STATUS`.
  - ASCII constants: CR, LF, SPACE, '0', '9', and the command letters.
- Sub-module `rx_byte_edge`: holds the previous-byte register and emits a `byte_evt` pulse plus the captured byte. It is reusable by other consumers of the receiver.
- Parser FSM, accumulator, timeout counter, and error counter live in `uart_cmd_parser`.

## Test plan
- Send "F\r" → `cmd_valid` 1 cycle after the CR event, with `cmd_code`=1 and `cmd_arg`=1. `err_count` stays 0.
- Send "p12\n" → `cmd_code`=2, `cmd_arg`=12. Then send "?\r" → `cmd_code`=7, `cmd_arg`=1.
- Send "C16\r" → `err` pulse, no `cmd_valid`, `err_count`=1. Then "C9\r" → `cmd_code`=3, `cmd_arg`=9.
- Send "X" → `err`. Then "FS\r" → `err` on S, and CR ignored in IDLE. Check `err_count`=2 and no `cmd_valid`.
- With `TIMEOUT_CYCLES`=100, send "W" then idle 100 cycles → `err` at cycle 99 after the W event, `busy` drops. Also send a byte exactly on the expiry cycle → no `err`.
- Assert `rst` for 1 cycle after "M1" → all outputs 0, then "\r" is ignored with no `cmd_valid`. Hold `rx_byte`=0x46 across reset release → exactly one byte event.

Source files
------------

// File: rtl/tama_pkg.sv
// Shared definitions for the pet-state command path: command codes,
// ASCII constants and small byte-classification helpers.
package tama_pkg;

  // Command codes driven on cmd_code. Zero never leaves the parser as a command.
  localparam logic [2:0] CMD_NONE   = 3'd0;
  localparam logic [2:0] CMD_FEED   = 3'd1;
  localparam logic [2:0] CMD_PLAY   = 3'd2;
  localparam logic [2:0] CMD_CLEAN  = 3'd3;
  localparam logic [2:0] CMD_SLEEP  = 3'd4;
  localparam logic [2:0] CMD_WAKE   = 3'd5;
  localparam logic [2:0] CMD_MEDS   = 3'd6;
  localparam logic [2:0] CMD_STATUS = 3'd7;

  // ASCII bytes the parser cares about (upper-case letter forms).
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_C     = 8'h43;
  localparam logic [7:0] ASCII_F     = 8'h46;
  localparam logic [7:0] ASCII_M     = 8'h4D;
  localparam logic [7:0] ASCII_P     = 8'h50;
  localparam logic [7:0] ASCII_S     = 8'h53;
  localparam logic [7:0] ASCII_W     = 8'h57;

  // Lower-case range and the bit that separates the two cases.
  localparam logic [7:0] ASCII_LC_A     = 8'h61;
  localparam logic [7:0] ASCII_LC_Z     = 8'h7A;
  localparam logic [7:0] ASCII_CASE_BIT = 8'h20;

  // Parser states. busy is simply "state is ST_ARG".
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ARG  = 1'b1
  } parse_state_e;

  // Map a byte to its command code; letters are case-insensitive,
  // anything that is not a command yields CMD_NONE.
  function automatic logic [2:0] cmd_of(input logic [7:0] b);
    logic [7:0] u;
    u = b;
    if (b >= ASCII_LC_A && b <= ASCII_LC_Z) u = b & ~ASCII_CASE_BIT;
    case (u)
      ASCII_F:     cmd_of = CMD_FEED;
      ASCII_P:     cmd_of = CMD_PLAY;
      ASCII_C:     cmd_of = CMD_CLEAN;
      ASCII_S:     cmd_of = CMD_SLEEP;
      ASCII_W:     cmd_of = CMD_WAKE;
      ASCII_M:     cmd_of = CMD_MEDS;
      ASCII_QMARK: cmd_of = CMD_STATUS;
      default:     cmd_of = CMD_NONE;
    endcase
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

  function automatic logic is_eol(input logic [7:0] b);
    return (b == ASCII_CR) || (b == ASCII_LF);
  endfunction

endpackage

// File: rtl/rx_byte_edge.sv
// Turns the receiver's level-style byte output (nonzero while a byte is
// ready, zero otherwise) into a one-cycle byte event. Reusable by any
// consumer of the UART receiver.
module rx_byte_edge (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  output logic       byte_evt,
  output logic [7:0] evt_byte
);

  logic [7:0] prev_byte;

  // Remember last cycle's byte; cleared on reset so a byte already held
  // when reset releases still produces exactly one event.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_byte <= 8'h00;
    end else begin
      prev_byte <= rx_byte;
    end
  end

  // A byte event is the zero-to-nonzero transition; a held byte is ignored
  // and 8'h00 can never be an event.
  assign byte_evt = (rx_byte != 8'h00) && (prev_byte == 8'h00);
  assign evt_byte = rx_byte;

endmodule

// File: rtl/uart_cmd_parser.sv
// ASCII command-line parser: one command letter, optional decimal amount,
// then CR or LF. Produces single-cycle command strobes for the pet-state
// logic and single-cycle error strobes with a saturating error count.
//
// Output contract: cmd_valid and err are single-cycle strobes with no
// back-pressure (there is no ready); a consumer must act in the strobe
// cycle. cmd_code/cmd_arg are stable from a cmd_valid until the next one.
// cmd_valid and err are never high together.
module uart_cmd_parser
  import tama_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 27_000_000,
  parameter logic [3:0] DEFAULT_ARG    = 4'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic [3:0] cmd_arg,
  output logic       err,
  output logic [7:0] err_count,
  output logic       busy
);

  // The counter is cleared in the cycle a byte is consumed, so in the cycle
  // that is TIMEOUT_CYCLES-1 cycles after the byte event it holds
  // TIMEOUT_CYCLES-2; that is the expiry cycle.
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 2);

  logic         byte_evt;
  logic [7:0]   evt_byte;

  parse_state_e state;
  logic [2:0]   code_q;
  logic [7:0]   acc;
  logic         has_digit;
  logic         ovf;
  logic [TW-1:0] tmo_cnt;

  logic [7:0]   acc_next;
  logic [2:0]   byte_cmd;

  rx_byte_edge u_edge (
    .clk      (clk),
    .rst      (rst),
    .rx_byte  (rx_byte),
    .byte_evt (byte_evt),
    .evt_byte (evt_byte)
  );

  // Decode the current byte: its command code and the accumulator value if
  // it were a digit. acc is frozen at <= 15 before any multiply, so the
  // result (max 159) always fits in 8 bits.
  always_comb begin
    byte_cmd = cmd_of(evt_byte);
    acc_next = (acc * 8'd10) + (evt_byte - ASCII_0);
  end

  // Parser FSM with registered strobes and held command outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      code_q    <= CMD_NONE;
      acc       <= 8'd0;
      has_digit <= 1'b0;
      ovf       <= 1'b0;
      tmo_cnt   <= '0;
      cmd_valid <= 1'b0;
      cmd_code  <= CMD_NONE;
      cmd_arg   <= 4'd0;
      err       <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      err       <= 1'b0;
      case (state)
        ST_IDLE: begin
          tmo_cnt <= '0;
          if (byte_evt) begin
            if (byte_cmd != CMD_NONE) begin
              code_q    <= byte_cmd;
              acc       <= 8'd0;
              has_digit <= 1'b0;
              ovf       <= 1'b0;
              state     <= ST_ARG;
            end else if (!is_eol(evt_byte) && evt_byte != ASCII_SPACE) begin
              err <= 1'b1;
            end
          end
        end

        ST_ARG: begin
          if (byte_evt) begin
            // A byte in the expiry cycle wins over the timeout.
            tmo_cnt <= '0;
            if (is_digit(evt_byte)) begin
              has_digit <= 1'b1;
              if (!ovf) begin
                if (acc_next > 8'd15) begin
                  ovf <= 1'b1;
                end else begin
                  acc <= acc_next;
                end
              end
            end else if (is_eol(evt_byte)) begin
              state <= ST_IDLE;
              if (ovf) begin
                err <= 1'b1;
              end else begin
                cmd_valid <= 1'b1;
                cmd_code  <= code_q;
                cmd_arg   <= has_digit ? acc[3:0] : DEFAULT_ARG;
              end
            end else if (evt_byte != ASCII_SPACE) begin
              // Includes a second letter: the whole line is dropped and the
              // byte is not reused as a new command.
              err   <= 1'b1;
              state <= ST_IDLE;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            err   <= 1'b1;
            state <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Saturating count of error strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= 8'd0;
    end else if (err && err_count != 8'hFF) begin
      err_count <= err_count + 8'd1;
    end
  end

  assign busy = (state == ST_ARG);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: byte driver tasks push expected strobes (with
// the cycle they must appear in) onto a scoreboard; a negedge monitor pops
// and compares every cmd_valid/err strobe.
module tb_uart_cmd_parser;

  localparam int TMO = 100;
  localparam logic [7:0] E_ERR = 8'h80;
  localparam logic [7:0] B_CR  = 8'h0D;
  localparam logic [7:0] B_LF  = 8'h0A;
  localparam logic [7:0] B_SP  = 8'h20;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_byte;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic [3:0] cmd_arg;
  logic       err;
  logic [7:0] err_count;
  logic       busy;

  uart_cmd_parser #(
    .TIMEOUT_CYCLES (TMO),
    .DEFAULT_ARG    (4'd1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_byte   (rx_byte),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .cmd_arg   (cmd_arg),
    .err       (err),
    .err_count (err_count),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];
  int         exp_cyc_q[$];
  int         exp_errs = 0;
  int         last_evt = 0;
  logic [7:0] mon_obs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic logic [7:0] vcmd(input logic [2:0] code, input logic [3:0] arg);
    return {1'b0, code, arg};
  endfunction

  task automatic push_exp(input logic [7:0] val, input int at_cyc);
    exp_q.push_back(val);
    exp_cyc_q.push_back(at_cyc);
    if (val == E_ERR && exp_errs < 255) exp_errs++;
  endtask

  // Strobe monitor: every strobe must match the head of the queue, in the
  // cycle recorded with it.
  always @(negedge clk) begin
    if (cmd_valid || err) begin
      if (cmd_valid && err) mon_obs = 8'hFF;
      else if (err)         mon_obs = E_ERR;
      else                  mon_obs = vcmd(cmd_code, cmd_arg);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", mon_obs, 8'h00);
      end else begin
        check("strobe", mon_obs, exp_q.pop_front());
        check("strobe_cycle", cyc, exp_cyc_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) idle(1);
  endtask

  // One byte: held for one cycle (the event cycle), then zero for one cycle.
  task automatic send_byte(input logic [7:0] b, input bit has_exp, input logic [7:0] val);
    @(posedge clk);
    #1;
    rx_byte  = b;
    last_evt = cyc;
    if (has_exp) push_exp(val, cyc + 1);
    @(posedge clk);
    #1;
    rx_byte = 8'h00;
  endtask

  task automatic send(input logic [7:0] b);
    send_byte(b, 1'b0, 8'h00);
  endtask

  task automatic check_err_count(input string tag);
    idle(3);
    check(tag, err_count, exp_errs);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {cmd_valid, err, cmd_code, cmd_arg, err_count, busy}, 0);
  endtask

  // ---------------- stimulus ----------------
  int n0;

  initial begin
    rst     = 1'b1;
    rx_byte = 8'h00;
    idle(2);
    check_all_zero("reset_outputs");
    rst = 1'b0;
    idle(2);
    check_all_zero("post_reset_idle");

    // "F\r" -> FEED, default amount
    send("F");
    check("busy_after_letter", busy, 1);
    send_byte(B_CR, 1'b1, vcmd(3'd1, 4'd1));
    check_err_count("err_count_after_F");
    check("busy_after_eol", busy, 0);

    // "p12\n" then "?\r"
    send("p"); send("1"); send("2");
    send_byte(B_LF, 1'b1, vcmd(3'd2, 4'd12));
    send("?");
    send_byte(B_CR, 1'b1, vcmd(3'd7, 4'd1));
    idle(2);
    check("held_code", cmd_code, 3'd7);
    check("held_arg", cmd_arg, 4'd1);

    // "C16\r" overflows, then "C9\r"
    send("C"); send("1"); send("6");
    send_byte(B_CR, 1'b1, E_ERR);
    check_err_count("err_count_after_C16");
    check("code_held_over_err", cmd_code, 3'd7);
    send("C"); send("9");
    send_byte(B_CR, 1'b1, vcmd(3'd3, 4'd9));

    // "X" in IDLE, then "FS\r": error on S, CR ignored in IDLE
    send_byte("X", 1'b1, E_ERR);
    send("F");
    send_byte("S", 1'b1, E_ERR);
    send(B_CR);
    check_err_count("err_count_after_FS");
    check("busy_after_FS", busy, 0);

    // Boundaries and spacing: 15, 0, leading zeros, spaces, lower case
    send("S"); send("1"); send("5");
    send_byte(B_CR, 1'b1, vcmd(3'd4, 4'd15));
    send("s"); send("0");
    send_byte(B_LF, 1'b1, vcmd(3'd4, 4'd0));
    send("F"); send("0"); send("0"); send("1"); send("5");
    send_byte(B_CR, 1'b1, vcmd(3'd1, 4'd15));
    send(B_SP); send("m"); send(B_SP); send("1"); send(B_SP); send("2");
    send_byte(B_CR, 1'b1, vcmd(3'd6, 4'd12));
    send("w");
    send_byte(B_LF, 1'b1, vcmd(3'd5, 4'd1));
    send("M");
    send_byte("/", 1'b1, E_ERR);
    check_err_count("err_count_after_bad_digit");

    // Timeout: "W" then silence -> err 100 cycles after the W event
    send("W");
    n0 = last_evt;
    push_exp(E_ERR, n0 + TMO);
    wait_cyc(n0 + TMO - 1);
    check("busy_before_timeout", busy, 1);
    idle(1);
    check("busy_after_timeout", busy, 0);

    // A byte in the expiry cycle wins over the timeout
    send("W");
    n0 = last_evt;
    wait_cyc(n0 + TMO - 2);
    send("5");
    check("expiry_byte_cycle", last_evt, n0 + TMO - 1);
    idle(4);
    check("busy_after_expiry_byte", busy, 1);
    send_byte(B_CR, 1'b1, vcmd(3'd5, 4'd5));
    check_err_count("err_count_after_timeouts");

    // Reset mid-command after "M1": everything clears, CR then ignored
    send("M"); send("1");
    check("busy_before_mid_reset", busy, 1);
    rst = 1'b1;
    idle(1);
    check_all_zero("mid_reset_outputs");
    rst = 1'b0;
    exp_errs = 0;
    send(B_CR);
    idle(2);
    check_all_zero("cr_after_reset");

    // Byte held across reset release: exactly one event
    rst     = 1'b1;
    rx_byte = "F";
    idle(1);
    rst = 1'b0;
    idle(5);
    check("busy_held_byte", busy, 1);
    rx_byte = 8'h00;
    idle(1);
    send_byte(B_CR, 1'b1, vcmd(3'd1, 4'd1));
    check_err_count("err_count_held_byte");

    // Saturation of err_count
    for (int i = 0; i < 260; i++) send_byte("X", 1'b1, E_ERR);
    check_err_count("err_count_saturated");
    check("err_count_255", err_count, 8'hFF);

    idle(5);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
